wb_write_demux: RTL and testbench

- Write-back-side counterpart of the ALU result-select mux. The mux narrows N sources to one output; this block widens one write-back result into one-hot write enables for the 32-entry ARM register file.
- Sits between the MEM/WB pipeline register and the register file.
- Buffers up to 2 pending writes when the register-file write port stalls.
- Supplies forwarding hit/data for pending writes to the decode stage.
- Writes to X31 (XZR) are consumed but never produce a write enable.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/decoder5to32.sv | 17 +
 rtl/wb_write_demux.sv | 110 +++++++++++
 tb/tb_wb_write_demux.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back demux and its decoder.
package wb_pkg;

    localparam int unsigned NREG     = 32;
    localparam int unsigned DW       = 64;
    localparam int unsigned AW       = 5;
    localparam int unsigned ZERO_REG = 31;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } wb_cnt_e;

    // A pending entry forwards only to a real (non-zero) architectural register.
    function automatic logic wb_addr_match(input logic [AW-1:0] entry_addr,
                                           input logic [AW-1:0] rd_addr);
        return (entry_addr == rd_addr) && (32'(rd_addr) != ZERO_REG);
    endfunction

endpackage

// File: rtl/decoder5to32.sv
// Register-address to one-hot enable decoder; out-of-range addresses decode to zero.
module decoder5to32
    import wb_pkg::*;
(
    input  logic            en,
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en && (32'(addr) < NREG)) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_write_demux.sv
// Two-entry write-back buffer feeding one-hot register-file write enables,
// with forwarding of still-pending writes to the decode stage.
module wb_write_demux
    import wb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_addr,
    input  logic [DW-1:0]   in_data,
    input  logic            stall,
    output logic [NREG-1:0] wr_en,
    output logic [DW-1:0]   wr_data,
    input  logic [AW-1:0]   fwd_addr_a,
    input  logic [AW-1:0]   fwd_addr_b,
    output logic            fwd_hit_a,
    output logic            fwd_hit_b,
    output logic [DW-1:0]   fwd_data_a,
    output logic [DW-1:0]   fwd_data_b,
    output logic            busy
);

    wb_cnt_e   r_count;
    logic      r_head;
    logic      r_tail;
    wb_entry_t r_entries [2];

    logic      w_nonempty;
    logic      w_push;
    logic      w_pop;
    logic      w_dec_en;
    wb_entry_t w_head_ent;
    wb_entry_t w_young_ent;
    logic      w_old_valid;

    assign w_nonempty  = (r_count != EMPTY);
    assign in_ready    = (r_count != FULL);
    assign busy        = w_nonempty;
    assign w_push      = in_valid & in_ready;
    assign w_pop       = w_nonempty & ~stall;
    assign w_head_ent  = r_entries[r_head];
    // The most recently written slot sits just behind the tail pointer.
    assign w_young_ent = r_entries[~r_tail];
    assign w_old_valid = (r_count == FULL);

    assign w_dec_en = w_pop && (32'(w_head_ent.addr) != ZERO_REG);
    assign wr_data  = w_nonempty ? w_head_ent.data : '0;

    decoder5to32 u_dec (
        .en     (w_dec_en),
        .addr   (w_head_ent.addr),
        .onehot (wr_en)
    );

    // Younger entry takes priority when both pending writes target the same register.
    always_comb begin
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        if (w_nonempty && wb_addr_match(w_young_ent.addr, fwd_addr_a)) begin
            fwd_hit_a  = 1'b1;
            fwd_data_a = w_young_ent.data;
        end else if (w_old_valid && wb_addr_match(w_head_ent.addr, fwd_addr_a)) begin
            fwd_hit_a  = 1'b1;
            fwd_data_a = w_head_ent.data;
        end
        if (w_nonempty && wb_addr_match(w_young_ent.addr, fwd_addr_b)) begin
            fwd_hit_b  = 1'b1;
            fwd_data_b = w_young_ent.data;
        end else if (w_old_valid && wb_addr_match(w_head_ent.addr, fwd_addr_b)) begin
            fwd_hit_b  = 1'b1;
            fwd_data_b = w_head_ent.data;
        end
    end

    // Buffer storage, pointers and occupancy state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= EMPTY;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_entries[r_tail] <= '{addr: in_addr, data: in_data};
                r_tail            <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case (r_count)
                EMPTY: if (w_push) r_count <= ONE;
                ONE: begin
                    if (w_push && !w_pop) begin
                        r_count <= FULL;
                    end else if (!w_push && w_pop) begin
                        r_count <= EMPTY;
                    end
                end
                FULL:    if (w_pop) r_count <= ONE;
                default: r_count <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_write_demux.sv
// Self-checking bench for wb_write_demux against a queue-based behavioural model.
module tb_wb_write_demux;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_addr = '0;
    logic [63:0] in_data = '0;
    logic        stall = 1'b0;
    logic [31:0] wr_en;
    logic [63:0] wr_data;
    logic [4:0]  fwd_addr_a = '0;
    logic [4:0]  fwd_addr_b = '0;
    logic        fwd_hit_a, fwd_hit_b;
    logic [63:0] fwd_data_a, fwd_data_b;
    logic        busy;

    int total = 0;
    int bad   = 0;

    wb_write_demux dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .stall(stall), .wr_en(wr_en), .wr_data(wr_data),
        .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: ordered list of pending writes.
    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;
    ent_t q[$];

    logic        pend_pop, pend_push;
    ent_t        pend_ent;
    logic        exp_ready, exp_busy, exp_hit_a, exp_hit_b;
    logic [31:0] exp_wr_en;
    logic [63:0] exp_wr_data, exp_fd_a, exp_fd_b;

    // Apply last cycle's model effects, drive new inputs, compute expectations.
    task automatic drive(input logic v, input logic [4:0] a, input logic [63:0] d,
                         input logic s, input logic [4:0] fa, input logic [4:0] fb);
        @(negedge clk);
        if (pend_pop) void'(q.pop_front());
        if (pend_push) q.push_back(pend_ent);
        in_valid = v; in_addr = a; in_data = d; stall = s;
        fwd_addr_a = fa; fwd_addr_b = fb;
        exp_ready   = (q.size() < 2);
        exp_busy    = (q.size() != 0);
        pend_pop    = (q.size() != 0) && !s;
        exp_wr_en   = (pend_pop && q[0].a != 5'd31) ? (32'd1 << q[0].a) : 32'd0;
        exp_wr_data = (q.size() != 0) ? q[0].d : 64'd0;
        exp_hit_a = 1'b0; exp_fd_a = '0; exp_hit_b = 1'b0; exp_fd_b = '0;
        foreach (q[i]) begin
            if (q[i].a == fa && fa != 5'd31) begin exp_hit_a = 1'b1; exp_fd_a = q[i].d; end
            if (q[i].a == fb && fb != 5'd31) begin exp_hit_b = 1'b1; exp_fd_b = q[i].d; end
        end
        pend_push = v && exp_ready;
        pend_ent  = '{a: a, d: d};
        #1;
    endtask

    task automatic model_clear();
        q.delete();
        pend_pop  = 1'b0;
        pend_push = 1'b0;
    endtask

    task automatic test_reset();
        model_clear();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (wr_en !== 32'd0 || wr_data !== 64'd0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            fwd_hit_a !== 1'b0 || fwd_hit_b !== 1'b0 || fwd_data_a !== 64'd0 || fwd_data_b !== 64'd0) begin
            bad++;
            $display("FAIL reset_state: wr_en=%h wr_data=%h rdy=%b busy=%b hit=%b%b got, want 0/0/1/0/00",
                     wr_en, wr_data, in_ready, busy, fwd_hit_a, fwd_hit_b);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, 5'd0, 5'd0);
        total++;
        if (in_ready !== 1'b1 || wr_en !== 32'd0) begin
            bad++; $display("FAIL single_accept: rdy=%b wr_en=%h want 1/0", in_ready, wr_en);
        end
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd5, 5'd0);
        total++;
        if (wr_en !== 32'h0000_0020 || wr_data !== 64'hDEAD_BEEF_0000_0001) begin
            bad++; $display("FAIL single_write: wr_en=%h wr_data=%h want 00000020/deadbeef00000001", wr_en, wr_data);
        end
        total++;
        if (fwd_hit_a !== 1'b1 || fwd_data_a !== 64'hDEAD_BEEF_0000_0001) begin
            bad++; $display("FAIL single_fwd: hit=%b data=%h want 1/deadbeef00000001", fwd_hit_a, fwd_data_a);
        end
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd5, 5'd0);
        total++;
        if (wr_en !== 32'd0 || busy !== 1'b0 || fwd_hit_a !== 1'b0) begin
            bad++; $display("FAIL single_retired: wr_en=%h busy=%b hit=%b want 0/0/0", wr_en, busy, fwd_hit_a);
        end
    endtask

    task automatic test_xzr();
        drive(1'b1, 5'd31, 64'h1234, 1'b0, 5'd31, 5'd31);
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd31, 5'd31);
        total++;
        if (busy !== 1'b1 || wr_en !== 32'd0 || fwd_hit_a !== 1'b0 || fwd_hit_b !== 1'b0) begin
            bad++; $display("FAIL xzr_pending: busy=%b wr_en=%h hit=%b%b want 1/0/00",
                            busy, wr_en, fwd_hit_a, fwd_hit_b);
        end
        total++;
        if (wr_data !== 64'h1234) begin
            bad++; $display("FAIL xzr_data: wr_data=%h want 1234", wr_data);
        end
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd31, 5'd31);
        total++;
        if (busy !== 1'b0 || wr_en !== 32'd0) begin
            bad++; $display("FAIL xzr_retired: busy=%b wr_en=%h want 0/0", busy, wr_en);
        end
    endtask

    task automatic test_stall_fill();
        drive(1'b1, 5'd3, 64'hA, 1'b1, 5'd3, 5'd4);
        drive(1'b1, 5'd3, 64'hB, 1'b1, 5'd3, 5'd4);
        total++;
        if (in_ready !== 1'b1 || fwd_hit_a !== 1'b1 || fwd_data_a !== 64'hA || wr_en !== 32'd0) begin
            bad++; $display("FAIL stall_one: rdy=%b hit=%b data=%h wr_en=%h want 1/1/a/0",
                            in_ready, fwd_hit_a, fwd_data_a, wr_en);
        end
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd4);
        total++;
        if (in_ready !== 1'b0 || fwd_hit_a !== 1'b1 || fwd_data_a !== 64'hB) begin
            bad++; $display("FAIL stall_full_fwd: rdy=%b hit=%b data=%h want 0/1/b", in_ready, fwd_hit_a, fwd_data_a);
        end
        total++;
        if (wr_en !== 32'd0 || fwd_hit_b !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL stall_full_hold: wr_en=%h hit_b=%b busy=%b want 0/0/1", wr_en, fwd_hit_b, busy);
        end
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd3, 5'd4);
        total++;
        if (wr_en !== 32'h8 || wr_data !== 64'hA) begin
            bad++; $display("FAIL stall_drain1: wr_en=%h wr_data=%h want 8/a", wr_en, wr_data);
        end
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd3, 5'd4);
        total++;
        if (wr_en !== 32'h8 || wr_data !== 64'hB || in_ready !== 1'b1) begin
            bad++; $display("FAIL stall_drain2: wr_en=%h wr_data=%h rdy=%b want 8/b/1", wr_en, wr_data, in_ready);
        end
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd3, 5'd4);
        total++;
        if (wr_en !== 32'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL stall_drained: wr_en=%h busy=%b want 0/0", wr_en, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] dat [31];
        int errs = 0;
        for (int i = 0; i <= 31; i++) begin
            if (i < 31) begin
                dat[i] = {$urandom, $urandom};
                drive(1'b1, 5'(i), dat[i], 1'b0, 5'd0, 5'd0);
            end else begin
                drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
            end
            total++;
            if (i == 0) begin
                if (wr_en !== 32'd0 || in_ready !== 1'b1) begin
                    errs++; bad++;
                    $display("FAIL b2b_%0d: wr_en=%h rdy=%b want 0/1", i, wr_en, in_ready);
                end
            end else if (wr_en !== (32'd1 << (i - 1)) || wr_data !== dat[i-1] || in_ready !== 1'b1) begin
                errs++; bad++;
                $display("FAIL b2b_%0d: wr_en=%h wr_data=%h rdy=%b want %h/%h/1",
                         i, wr_en, wr_data, in_ready, 32'd1 << (i - 1), dat[i-1]);
            end
            if (errs > 4) break;
        end
    endtask

    task automatic test_random_traffic();
        int exp_pulses = 0;
        int obs_pulses = 0;
        for (int i = 0; i < 400; i++) begin
            logic v;
            logic s;
            v = (i < 396) && ($urandom_range(0, 3) != 0);
            s = (i < 396) ? ((i % 4) < 2) : 1'b0;
            if (i >= 200 && i < 396) s = ($urandom_range(0, 2) == 0);
            drive(v, 5'($urandom_range(0, 31)), {$urandom, $urandom}, s,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (exp_wr_en != 32'd0) exp_pulses++;
            if (wr_en != 32'd0) obs_pulses++;
            total++;
            if (wr_en !== exp_wr_en || wr_data !== exp_wr_data) begin
                bad++; $display("FAIL rand_write_%0d: wr_en=%h wr_data=%h want %h/%h",
                                i, wr_en, wr_data, exp_wr_en, exp_wr_data);
            end
            total++;
            if (in_ready !== exp_ready || busy !== exp_busy) begin
                bad++; $display("FAIL rand_status_%0d: rdy=%b busy=%b want %b/%b",
                                i, in_ready, busy, exp_ready, exp_busy);
            end
            total++;
            if (fwd_hit_a !== exp_hit_a || fwd_data_a !== exp_fd_a) begin
                bad++; $display("FAIL rand_fwd_a_%0d: hit=%b data=%h want %b/%h",
                                i, fwd_hit_a, fwd_data_a, exp_hit_a, exp_fd_a);
            end
            total++;
            if (fwd_hit_b !== exp_hit_b || fwd_data_b !== exp_fd_b) begin
                bad++; $display("FAIL rand_fwd_b_%0d: hit=%b data=%h want %b/%h",
                                i, fwd_hit_b, fwd_data_b, exp_hit_b, exp_fd_b);
            end
        end
        total++;
        if (obs_pulses != exp_pulses || exp_pulses == 0) begin
            bad++; $display("FAIL rand_pulse_count: got %0d want %0d (nonzero)", obs_pulses, exp_pulses);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 5'd7, 64'h1111, 1'b1, 5'd7, 5'd7);
        drive(1'b1, 5'd7, 64'h2222, 1'b1, 5'd7, 5'd7);
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd7);
        total++;
        if (in_ready !== 1'b0 || fwd_hit_a !== 1'b1 || fwd_data_a !== 64'h2222) begin
            bad++; $display("FAIL rst_pre_full: rdy=%b hit=%b data=%h want 0/1/2222", in_ready, fwd_hit_a, fwd_data_a);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (wr_en !== 32'd0 || wr_data !== 64'd0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            fwd_hit_a !== 1'b0 || fwd_hit_b !== 1'b0 || fwd_data_a !== 64'd0 || fwd_data_b !== 64'd0) begin
            bad++; $display("FAIL rst_async: wr_en=%h wr_data=%h rdy=%b busy=%b hit=%b%b want 0/0/1/0/00",
                            wr_en, wr_data, in_ready, busy, fwd_hit_a, fwd_hit_b);
        end
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd7, 5'd7);
            total++;
            if (wr_en !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0 || fwd_hit_a !== 1'b0) begin
                bad++; $display("FAIL rst_no_stale_%0d: wr_en=%h rdy=%b busy=%b hit=%b want 0/1/0/0",
                                i, wr_en, in_ready, busy, fwd_hit_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_xzr();
        test_stall_fill();
        test_back_to_back();
        test_random_traffic();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
